au_op_sequencer: RTL and testbench

//  Initiator side of the AU start/done protocol. Accepts register-addressed AU instructions over a

---
 rtl/kf_au_pkg.sv | 43 ++++
 rtl/au_regfile.sv | 46 ++++
 rtl/au_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_au_op_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_au_pkg.sv
// Shared definitions for the Kalman-filter arithmetic unit and its sequencer:
// word format, opcodes, multiplier Y selects and sign-magnitude helpers.
package kf_au_pkg;

   localparam int AU_W    = 24;
   localparam int AU_FRAC = 14;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] MY_S   = 2'b00;
   localparam logic [1:0] MY_IMM = 2'b01;
   localparam logic [1:0] MY_INV = 2'b10;
   localparam logic [1:0] MY_ILL = 2'b11;

   localparam logic [AU_W-1:0] Q_ONE = AU_W'(1) << AU_FRAC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } seq_state_t;

   function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] muly);
      return (op == OP_MUL) && (muly == MY_ILL);
   endfunction

   // Operations that go through the AU reciprocal path and so cannot take |S| = 0.
   function automatic logic needs_recip(input logic [1:0] op, input logic [1:0] muly);
      return (op == OP_DIV) || ((op == OP_MUL) && (muly == MY_INV));
   endfunction

   function automatic logic [AU_W-2:0] sm_mag(input logic [AU_W-1:0] x);
      return x[AU_W-2:0];
   endfunction

   function automatic logic [AU_W-1:0] sm_neg(input logic [AU_W-1:0] x);
      return {~x[AU_W-1], x[AU_W-2:0]};
   endfunction

endpackage

// File: rtl/au_regfile.sv
// Sign-magnitude register file: three combinational read ports, a writeback
// port and a host port (writeback wins on an address clash), synchronous clear.
module au_regfile #(
   parameter int W    = 24,
   parameter int NREG = 16,
   parameter int AW   = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [AW-1:0] ra_addr,
   output logic [W-1:0]  ra_data,
   input  logic [AW-1:0] rb_addr,
   output logic [W-1:0]  rb_data,
   input  logic [AW-1:0] hr_addr,
   output logic [W-1:0]  hr_data,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  logic [W-1:0]  wb_data,
   input  logic          host_en,
   input  logic [AW-1:0] host_addr,
   input  logic [W-1:0]  host_data
);

   logic [W-1:0] mem [NREG];

   assign ra_data = mem[ra_addr];
   assign rb_data = mem[rb_addr];
   assign hr_data = mem[hr_addr];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREG; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (host_en) begin
            mem[host_addr] <= host_data;
         end
         // Issued last so it overrides a host write to the same address.
         if (wb_en) begin
            mem[wb_addr] <= wb_data;
         end
      end
   end

endmodule

// File: rtl/au_op_sequencer.sv
// Initiator side of the AU start/done handshake: accepts one instruction at a
// time, issues it to the AU, waits for done (with a watchdog) and writes back.
module au_op_sequencer
   import kf_au_pkg::*;
#(
   parameter int W    = AU_W,
   parameter int NREG = 16,
   parameter int AW   = 4,
   parameter int TMO  = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [1:0]    instr_op,
   input  logic [1:0]    instr_muly,
   input  logic [AW-1:0] instr_ra,
   input  logic [AW-1:0] instr_rb,
   input  logic [AW-1:0] instr_rd,
   input  logic [W-1:0]  instr_imm,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   output logic          au_start,
   output logic [W-1:0]  au_R,
   output logic [W-1:0]  au_S,
   output logic [W-1:0]  au_Iimm,
   output logic [1:0]    au_op_sel,
   output logic [1:0]    au_mul_y_sel,
   input  logic [W-1:0]  au_result,
   input  logic          au_done,
   input  logic          au_busy,
   output logic          seq_busy,
   output logic          err_timeout,
   output logic          err_illegal,
   output logic          err_divz,
   input  logic          err_clr,
   output logic [15:0]   ops_done
);

   localparam int WDW = $clog2(TMO) + 1;

   seq_state_t    state_reg;
   logic [WDW-1:0] wdog_reg;
   logic [AW-1:0] rd_reg;
   logic [W-1:0]  ra_data;
   logic [W-1:0]  rb_data;
   logic          wb_en;
   logic          unused_au_busy;

   assign unused_au_busy = au_busy;
   assign wb_en = (state_reg == ST_WAIT) && au_done;

   au_regfile #(
      .W    (W),
      .NREG (NREG),
      .AW   (AW)
   ) u_regfile (
      .clk       (clk),
      .clr       (~rst_n),
      .ra_addr   (instr_ra),
      .ra_data   (ra_data),
      .rb_addr   (instr_rb),
      .rb_data   (rb_data),
      .hr_addr   (rd_addr),
      .hr_data   (rd_data),
      .wb_en     (wb_en),
      .wb_addr   (rd_reg),
      .wb_data   (au_result),
      .host_en   (wr_en),
      .host_addr (wr_addr),
      .host_data (wr_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         wdog_reg     <= '0;
         rd_reg       <= '0;
         instr_ready  <= 1'b1;
         seq_busy     <= 1'b0;
         au_start     <= 1'b0;
         au_R         <= '0;
         au_S         <= '0;
         au_Iimm      <= '0;
         au_op_sel    <= '0;
         au_mul_y_sel <= '0;
         err_timeout  <= 1'b0;
         err_illegal  <= 1'b0;
         err_divz     <= 1'b0;
         ops_done     <= '0;
      end else begin
         // Clear first; any error raised below in the same cycle overrides it.
         if (err_clr) begin
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            err_divz    <= 1'b0;
         end

         case (state_reg)
            ST_IDLE: begin
               if (instr_valid) begin
                  au_R         <= ra_data;
                  au_S         <= rb_data;
                  au_Iimm      <= instr_imm;
                  au_op_sel    <= instr_op;
                  au_mul_y_sel <= instr_muly;
                  rd_reg       <= instr_rd;
                  if (is_illegal(instr_op, instr_muly)) begin
                     err_illegal <= 1'b1;
                  end else begin
                     state_reg   <= ST_ISSUE;
                     au_start    <= 1'b1;
                     instr_ready <= 1'b0;
                     seq_busy    <= 1'b1;
                  end
               end
            end

            ST_ISSUE: begin
               au_start  <= 1'b0;
               wdog_reg  <= '0;
               state_reg <= ST_WAIT;
               if (needs_recip(au_op_sel, au_mul_y_sel) && (au_S[W-2:0] == '0)) begin
                  err_divz <= 1'b1;
               end
            end

            ST_WAIT: begin
               wdog_reg <= wdog_reg + WDW'(1);
               if (au_done) begin
                  ops_done    <= ops_done + 16'd1;
                  state_reg   <= ST_IDLE;
                  instr_ready <= 1'b1;
                  seq_busy    <= 1'b0;
               end else if (wdog_reg == WDW'(TMO - 1)) begin
                  err_timeout <= 1'b1;
                  state_reg   <= ST_IDLE;
                  instr_ready <= 1'b1;
                  seq_busy    <= 1'b0;
               end
            end

            default: begin
               state_reg   <= ST_IDLE;
               instr_ready <= 1'b1;
               seq_busy    <= 1'b0;
               au_start    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_au_op_sequencer.sv
// Bench for au_op_sequencer: behavioural AU stub plus a register-file model,
// directed scenarios followed by randomized instructions.
module tb_au_op_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [1:0]  instr_op;
   logic [1:0]  instr_muly;
   logic [3:0]  instr_ra, instr_rb, instr_rd;
   logic [23:0] instr_imm;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [23:0] wr_data;
   logic [3:0]  rd_addr;
   logic [23:0] rd_data;
   logic        au_start;
   logic [23:0] au_R, au_S, au_Iimm;
   logic [1:0]  au_op_sel, au_mul_y_sel;
   logic [23:0] au_result;
   logic        au_done;
   logic        au_busy;
   logic        seq_busy;
   logic        err_timeout, err_illegal, err_divz;
   logic        err_clr;
   logic [15:0] ops_done;

   int ntests = 0;
   int nfail  = 0;

   logic [23:0] model_rf [16];
   int          mops;
   bit          exp_tmo, exp_ill, exp_divz;
   bit          au_hang;

   always #5 clk = ~clk;

   au_op_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_op     (instr_op),
      .instr_muly   (instr_muly),
      .instr_ra     (instr_ra),
      .instr_rb     (instr_rb),
      .instr_rd     (instr_rd),
      .instr_imm    (instr_imm),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .au_start     (au_start),
      .au_R         (au_R),
      .au_S         (au_S),
      .au_Iimm      (au_Iimm),
      .au_op_sel    (au_op_sel),
      .au_mul_y_sel (au_mul_y_sel),
      .au_result    (au_result),
      .au_done      (au_done),
      .au_busy      (au_busy),
      .seq_busy     (seq_busy),
      .err_timeout  (err_timeout),
      .err_illegal  (err_illegal),
      .err_divz     (err_divz),
      .err_clr      (err_clr),
      .ops_done     (ops_done)
   );

   // ---------------- Q14 sign-magnitude arithmetic ----------------
   function automatic longint sm2i(input logic [23:0] x);
      longint m;
      m = longint'(x[22:0]);
      return x[23] ? -m : m;
   endfunction

   function automatic logic [23:0] i2sm(input longint v);
      longint m;
      logic [22:0] mag;
      m = (v < 0) ? -v : v;
      if (m > 64'sh7FFFFF) m = 64'sh7FFFFF;
      mag = m[22:0];
      return {(v < 0), mag};
   endfunction

   function automatic logic [23:0] au_calc(input logic [1:0] op, input logic [1:0] muly,
                                           input logic [23:0] r, input logic [23:0] s,
                                           input logic [23:0] imm);
      longint ri, si, ii, y;
      ri = sm2i(r);
      si = sm2i(s);
      ii = sm2i(imm);
      case (op)
         2'b00: return i2sm(ri + si);
         2'b01: return i2sm(ri - si);
         2'b10: begin
            if (muly == 2'b00)      y = si;
            else if (muly == 2'b01) y = ii;
            else if (muly == 2'b10) y = (si == 0) ? 64'sh7FFFFF : (64'sd1 <<< 28) / si;
            else                    y = 0;
            return i2sm((ri * y) / 16384);
         end
         default: begin
            if (si == 0) return i2sm((ri < 0) ? -64'sh7FFFFF : 64'sh7FFFFF);
            return i2sm((ri * 16384) / si);
         end
      endcase
   endfunction

   // AU stub: 2-cycle latency, 26 for reciprocal ops; reads operands when finishing.
   int au_cnt;
   bit au_pend;
   always @(posedge clk) begin
      if (!rst_n) begin
         au_pend   <= 1'b0;
         au_cnt    <= 0;
         au_done   <= 1'b0;
         au_result <= '0;
      end else begin
         au_done <= 1'b0;
         if (au_start) begin
            au_pend <= !au_hang;
            au_cnt  <= ((au_op_sel == 2'b11) || (au_op_sel == 2'b10 && au_mul_y_sel == 2'b10)) ? 26 : 2;
         end else if (au_pend) begin
            if (au_cnt <= 1) begin
               au_done   <= 1'b1;
               au_result <= au_calc(au_op_sel, au_mul_y_sel, au_R, au_S, au_Iimm);
               au_pend   <= 1'b0;
            end else begin
               au_cnt <= au_cnt - 1;
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntests++;
      assert (obs === expv) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic host_write(input logic [3:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      step();
      wr_en = 1'b0;
      model_rf[a] = d;
   endtask

   task automatic check_rf(input string tag, input logic [3:0] a, input logic [23:0] expv);
      rd_addr = a;
      #1;
      check(tag, 32'(rd_data), 32'(expv));
   endtask

   task automatic check_flags();
      check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
      check("err_illegal", 32'(err_illegal), 32'(exp_ill));
      check("err_divz",    32'(err_divz),    32'(exp_divz));
      check("ops_done",    32'(ops_done),    32'(mops & 16'hFFFF));
   endtask

   // hw_mode: 0 none, 1 host write on first WAIT cycle, 2 host write on the au_done cycle
   task automatic run(input logic [1:0] op, input logic [1:0] muly, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [3:0] rd, input logic [23:0] imm,
                      input bit hold, input int hw_mode, input logic [3:0] hw_a,
                      input logic [23:0] hw_d);
      logic [23:0] exp_res, r0, s0;
      bit ill, recip, hw_done, stable, rdy_ok, expired;
      int starts, waited;
      ill   = (op == 2'b10) && (muly == 2'b11);
      recip = (op == 2'b11) || (op == 2'b10 && muly == 2'b10);
      exp_res = au_calc(op, muly, model_rf[ra], model_rf[rb], imm);
      if (ill) exp_ill = 1'b1;
      if (!ill && recip && model_rf[rb][22:0] == 23'd0) exp_divz = 1'b1;

      instr_valid = 1'b1; instr_op = op; instr_muly = muly;
      instr_ra = ra; instr_rb = rb; instr_rd = rd; instr_imm = imm;
      step();
      if (!hold) instr_valid = 1'b0;
      starts = 0; waited = 0; stable = 1'b1; rdy_ok = 1'b1; hw_done = 1'b0; expired = 1'b1;
      r0 = au_R; s0 = au_S;
      for (int i = 0; i < 300; i++) begin
         if (!seq_busy) begin
            expired = 1'b0;
            break;
         end
         if (au_start) starts++; else waited++;
         if (au_R !== r0 || au_S !== s0) stable = 1'b0;
         if (instr_ready !== 1'b0) rdy_ok = 1'b0;
         if (!hw_done && ((hw_mode == 1 && !au_start) || (hw_mode == 2 && au_done))) begin
            wr_en = 1'b1; wr_addr = hw_a; wr_data = hw_d;
            model_rf[hw_a] = hw_d;
            hw_done = 1'b1;
         end
         step();
         wr_en = 1'b0;
      end
      instr_valid = 1'b0;
      if (!ill) begin
         if (au_hang) exp_tmo = 1'b1;
         else begin
            model_rf[rd] = exp_res;
            mops++;
         end
      end

      check("wait_bound", 32'(expired), 32'd0);
      check("start_pulses", 32'(starts), ill ? 32'd0 : 32'd1);
      check("ready_low_in_wait", 32'(rdy_ok), 32'd1);
      check("operands_stable", 32'(stable), 32'd1);
      if (au_hang) check("wdog_cycles", 32'(waited), 32'd64);
      check("instr_ready_back", 32'(instr_ready), 32'd1);
      check_rf("rf_dest", rd, model_rf[rd]);
      check_flags();
      $display("[TB] op=%0d muly=%0d ra=%0d rb=%0d rd=%0d imm=%06h -> rf[rd]=%06h ops=%0d",
               op, muly, ra, rb, rd, imm, rd_data, ops_done);
   endtask

   function automatic logic [23:0] rnd_sm();
      logic [22:0] m;
      m = 23'($urandom_range(0, 32'h1FFFF));
      return {1'($urandom_range(0, 1)), m};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_muly = '0;
      instr_ra = '0; instr_rb = '0; instr_rd = '0; instr_imm = '0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      au_busy = 1'b0; err_clr = 1'b0; au_hang = 1'b0;
      for (int i = 0; i < 16; i++) model_rf[i] = '0;
      mops = 0; exp_tmo = 0; exp_ill = 0; exp_divz = 0;
      step(); step();
      rst_n = 1'b1;

      // Reset state
      check("rst_instr_ready", 32'(instr_ready), 32'd1);
      check("rst_seq_busy", 32'(seq_busy), 32'd0);
      check("rst_au_start", 32'(au_start), 32'd0);
      check("rst_au_R", 32'(au_R), 32'd0);
      check_flags();
      check_rf("rst_rf5", 4'd5, 24'h0);

      // 1. ADD
      host_write(4'd1, 24'h006000);
      host_write(4'd2, 24'h002000);
      run(2'b00, 2'b00, 4'd1, 4'd2, 4'd3, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      check_rf("add_value", 4'd3, 24'h008000);

      // 2. SUB and MUL by immediate
      run(2'b01, 2'b00, 4'd2, 4'd1, 4'd4, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      check_rf("sub_value", 4'd4, 24'h804000);
      run(2'b10, 2'b01, 4'd1, 4'd0, 4'd5, 24'h804000, 1'b0, 0, 4'd0, 24'h0);
      check_rf("mul_imm_value", 4'd5, 24'h806000);

      // 3. DIV with instr_valid held through the wait
      run(2'b11, 2'b00, 4'd1, 4'd2, 4'd6, 24'h0, 1'b1, 0, 4'd0, 24'h0);
      check_rf("div_value", 4'd6, 24'h00C000);

      // 4. Watchdog, error clear, illegal, divide by zero
      au_hang = 1'b1;
      run(2'b00, 2'b00, 4'd1, 4'd2, 4'd12, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      au_hang = 1'b0;
      err_clr = 1'b1; step(); err_clr = 1'b0;
      exp_tmo = 0; exp_ill = 0; exp_divz = 0;
      check_flags();
      run(2'b10, 2'b11, 4'd1, 4'd2, 4'd13, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      run(2'b11, 2'b00, 4'd1, 4'd0, 4'd14, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      // err_clr together with a new illegal instruction: the new error survives
      instr_valid = 1'b1; instr_op = 2'b10; instr_muly = 2'b11; err_clr = 1'b1;
      step();
      instr_valid = 1'b0; err_clr = 1'b0;
      exp_tmo = 0; exp_ill = 1; exp_divz = 0;
      check_flags();

      // 5. Host writes racing the writeback
      run(2'b00, 2'b00, 4'd1, 4'd2, 4'd7, 24'h0, 1'b0, 2, 4'd7, 24'h123456);
      run(2'b00, 2'b00, 4'd1, 4'd1, 4'd8, 24'h0, 1'b0, 2, 4'd9, 24'h00ABCD);
      check_rf("host_other_addr", 4'd9, 24'h00ABCD);
      run(2'b10, 2'b01, 4'd1, 4'd0, 4'd11, 24'h004000, 1'b0, 1, 4'd1, 24'h000100);
      check_rf("inflight_ra_write", 4'd11, 24'h006000);

      // 6. Reset in the middle of a DIV wait
      instr_valid = 1'b1; instr_op = 2'b11; instr_muly = 2'b00;
      instr_ra = 4'd4; instr_rb = 4'd2; instr_rd = 4'd6;
      step();
      instr_valid = 1'b0;
      repeat (5) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) model_rf[i] = '0;
      mops = 0; exp_tmo = 0; exp_ill = 0; exp_divz = 0;
      check("midrst_instr_ready", 32'(instr_ready), 32'd1);
      check("midrst_seq_busy", 32'(seq_busy), 32'd0);
      check("midrst_au_S", 32'(au_S), 32'd0);
      check_flags();
      check_rf("midrst_rf1", 4'd1, 24'h0);
      repeat (40) step();
      check_rf("midrst_no_late_wb", 4'd6, 24'h0);
      check("midrst_ops_done", 32'(ops_done), 32'd0);
      host_write(4'd1, 24'h006000);
      host_write(4'd2, 24'h002000);
      run(2'b00, 2'b00, 4'd1, 4'd2, 4'd3, 24'h0, 1'b0, 0, 4'd0, 24'h0);
      check_rf("post_rst_add", 4'd3, 24'h008000);

      // Randomized instructions against the model
      for (int k = 0; k < 24; k++) begin
         logic [1:0] op, my;
         logic [3:0] ra, rb, rd;
         op = 2'($urandom_range(0, 3));
         my = 2'($urandom_range(0, 3));
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rd = 4'($urandom_range(0, 15));
         host_write(4'($urandom_range(0, 15)), rnd_sm());
         run(op, my, ra, rb, rd, rnd_sm(), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), rnd_sm());
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
